// File: rtl/clb_ecb_core_if.sv
// clb_ecb_core_if: host/consumer bus of the block cipher core
interface clb_ecb_core_if;
  logic         mode;
  logic [127:0] textin;
  logic [255:0] key;
  logic [127:0] textout;
  logic         enable;
  modport master (output mode, textin, key, input textout, enable);
  modport slave (input mode, textin, key, output textout, enable);
endinterface

// File: rtl/clb_ecb_core.sv
// clb_ecb_core: iterative 128-bit Feistel block cipher, 256-bit key, one round per clock
module clb_ecb_core (
  input logic           clk,
  input logic           rst,
  clb_ecb_core_if.slave io_bus
);
  typedef enum logic [1:0] {LOAD, KEYPREP, ROUND, DONE} state_t;
  state_t           r_state;
  logic [4:0]       r_cnt;
  logic             r_mode;
  logic [0:3][31:0] r_x;
  logic [0:7][31:0] r_w;
  logic             w_back;
  logic [4:0]       w_i;
  logic [31:0]      w_ck, w_fwd_k, w_bwd_k, w_rk;
  logic [0:7][31:0] w_w_next;
  logic [0:3][31:0] w_x_next;

  function automatic logic [31:0] sub(input logic [31:0] x);
    logic [0:15][3:0] tbl;
    logic [31:0] r;
    tbl = 64'hC56B90AD3EF84712;
    for (int n = 0; n < 8; n++) r[4*n +: 4] = tbl[x[4*n +: 4]];
    return r;
  endfunction

  function automatic logic [31:0] rotl(input logic [31:0] b, input int n);
    return (b << n) | (b >> (32 - n));
  endfunction

  function automatic logic [31:0] t_data(input logic [31:0] x);
    logic [31:0] b;
    b = sub(x);
    return b ^ rotl(b, 2) ^ rotl(b, 10) ^ rotl(b, 18) ^ rotl(b, 24);
  endfunction

  function automatic logic [31:0] t_key(input logic [31:0] x);
    logic [31:0] b;
    b = sub(x);
    return b ^ rotl(b, 13) ^ rotl(b, 23);
  endfunction

  // decryption rounds walk the key window backwards, so the round index counts down
  assign w_back   = (r_state == ROUND) && r_mode;
  assign w_i      = w_back ? ~r_cnt : r_cnt;
  assign w_ck     = {4{3'b000, w_i}};
  assign w_fwd_k  = r_w[0] ^ t_key(r_w[1] ^ r_w[7] ^ w_ck);
  assign w_bwd_k  = r_w[7] ^ t_key(r_w[0] ^ r_w[6] ^ w_ck);
  assign w_rk     = r_mode ? r_w[7] : w_fwd_k;
  assign w_w_next = w_back ? {w_bwd_k, r_w[0:6]} : {r_w[1:7], w_fwd_k};
  assign w_x_next = {r_x[1], r_x[2], r_x[3], r_x[0] ^ t_data(r_x[1] ^ r_x[2] ^ r_x[3] ^ w_rk)};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= LOAD;
      r_cnt          <= '0;
      r_mode         <= 1'b0;
      r_x            <= '0;
      r_w            <= '0;
      io_bus.textout <= '0;
      io_bus.enable  <= 1'b0;
    end else begin
      case (r_state)
        LOAD: begin
          r_x     <= io_bus.textin;
          r_w     <= io_bus.key;
          r_mode  <= io_bus.mode;
          r_cnt   <= '0;
          r_state <= io_bus.mode ? KEYPREP : ROUND;
        end
        KEYPREP: begin
          r_w   <= w_w_next;
          r_cnt <= r_cnt + 5'd1;
          if (r_cnt == 5'd31) r_state <= ROUND;
        end
        ROUND: begin
          r_x   <= w_x_next;
          r_w   <= w_w_next;
          r_cnt <= r_cnt + 5'd1;
          if (r_cnt == 5'd31) begin
            io_bus.textout <= {w_x_next[3], w_x_next[2], w_x_next[1], w_x_next[0]};
            io_bus.enable  <= 1'b1;
            r_state        <= DONE;
          end
        end
        default: r_state <= DONE;
      endcase
    end
  end
endmodule

// File: tb/tb_clb_ecb_core.sv
// tb_clb_ecb_core: directed and randomized checks of clb_ecb_core against a key-expansion model
module tb_clb_ecb_core;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int vectors = 0;
  int miscompares = 0;
  localparam logic [255:0] K1 = 256'hf8824664994aef9b418ca843498d658ff8824664994aef9b418ca843498d658f;
  localparam logic [127:0] P1 = 128'hfe5180a5414b65bf26f6d2122b004aff;
  localparam logic [255:0] K2 = 256'h0123456789abcdeffedcba98765432100f1f2f3f4f5f6f7f8f9fafbfcfdfefff;
  localparam logic [127:0] P2 = 128'h5c6f7253ae2c480d497422de7b4c40d3;

  clb_ecb_core_if bus ();
  clb_ecb_core dut (.clk(clk), .rst(rst), .io_bus(bus));

  always #5 clk = ~clk;

  function automatic logic [31:0] m_rotl(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction

  function automatic logic [31:0] m_s(input logic [31:0] x);
    int sb [16] = '{12, 5, 6, 11, 9, 0, 10, 13, 3, 14, 15, 8, 4, 7, 1, 2};
    logic [31:0] r = 0;
    for (int n = 0; n < 8; n++) r = r | (32'(sb[(x >> (4 * n)) & 32'hf]) << (4 * n));
    return r;
  endfunction

  // full key expansion up front, then straight-line rounds over an array of words
  function automatic logic [127:0] m_cipher(input logic [255:0] key, input logic [127:0] txt, input bit dec);
    logic [31:0] k [40];
    logic [31:0] x [36];
    logic [31:0] b, rk;
    for (int i = 0; i < 8; i++) k[i] = key[255 - 32 * i -: 32];
    for (int i = 0; i < 32; i++) begin
      b = m_s(k[i + 1] ^ k[i + 7] ^ (32'(i) * 32'h01010101));
      k[i + 8] = k[i] ^ b ^ m_rotl(b, 13) ^ m_rotl(b, 23);
    end
    for (int i = 0; i < 4; i++) x[i] = txt[127 - 32 * i -: 32];
    for (int r = 0; r < 32; r++) begin
      rk = dec ? k[39 - r] : k[r + 8];
      b = m_s(x[r + 1] ^ x[r + 2] ^ x[r + 3] ^ rk);
      x[r + 4] = x[r] ^ b ^ m_rotl(b, 2) ^ m_rotl(b, 10) ^ m_rotl(b, 18) ^ m_rotl(b, 24);
    end
    return {x[35], x[34], x[33], x[32]};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic scramble();
    bus.mode   = 1'($urandom);
    bus.textin = {$urandom, $urandom, $urandom, $urandom};
    bus.key    = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endtask

  // one full operation from reset release; latency and result are both checked
  task automatic run(input logic m, input logic [255:0] k, input logic [127:0] t,
                     input bit scr, output logic [127:0] res);
    int lat = m ? 65 : 33;
    int first = 0;
    logic [127:0] exp = m_cipher(k, t, m);
    rst = 1'b1;
    bus.mode = m;
    bus.key = k;
    bus.textin = t;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int e = 1; e <= lat + 3; e++) begin
      @(posedge clk);
      #1;
      if (scr) scramble();
      if (bus.enable && first == 0) first = e;
      if (e == lat - 1) begin
        chk("pre_valid_enable", 128'(bus.enable), '0);
        chk("pre_valid_textout", bus.textout, '0);
      end
    end
    chk("latency", 128'(first), 128'(lat));
    chk("result", bus.textout, exp);
    res = bus.textout;
  endtask

  initial begin
    logic [127:0] c1, c2, r, t;
    logic [255:0] k;
    logic m;
    scramble();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      scramble();
      chk("reset_textout", bus.textout, '0);
      chk("reset_enable", 128'(bus.enable), '0);
    end

    run(1'b0, K1, P1, 1'b0, c1);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      scramble();
      chk("hold_textout", bus.textout, c1);
    end
    chk("hold_enable", 128'(bus.enable), 128'(1));
    run(1'b1, K1, c1, 1'b0, r);
    chk("roundtrip_k1", r, P1);

    run(1'b0, K2, P2, 1'b0, c2);
    run(1'b1, K2, c2, 1'b0, r);
    chk("roundtrip_k2", r, P2);

    rst = 1'b1;
    #1;
    chk("async_clear_textout", bus.textout, '0);
    chk("async_clear_enable", 128'(bus.enable), '0);

    bus.mode = 1'b0;
    bus.key = K1;
    bus.textin = P1;
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("abort_textout", bus.textout, '0);
    chk("abort_enable", 128'(bus.enable), '0);
    run(1'b0, K1, P1, 1'b0, r);
    chk("rerun_after_abort", r, c1);

    run(1'b0, K2, P2, 1'b1, r);
    chk("isolation_enc", r, c2);
    run(1'b1, K2, c2, 1'b1, r);
    chk("isolation_dec", r, P2);

    for (int i = 0; i < 4; i++) begin
      k = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      t = {$urandom, $urandom, $urandom, $urandom};
      m = 1'($urandom);
      run(m, k, t, 1'($urandom), r);
      run(~m, k, r, 1'b0, c1);
      chk("random_roundtrip", c1, t);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
